// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: debug run/halt/step FSM plus load-use stall and branch flush control with event counters
//   in : Clock, Reset (sync, active-high), id_rs/id_rt[4:0], id_use_rs/id_use_rt,
//        exe_d[4:0], exe_wreg, exe_m2reg, btaken, halt_req, run_req, step_req
//   out: pipe_en, pc_en, ifid_en, ifid_flush, idexe_flush, state[1:0], stall_cnt[15:0], flush_cnt[15:0]
module pipe_hazard_ctrl (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  exe_d,
  input  logic        exe_wreg,
  input  logic        exe_m2reg,
  input  logic        btaken,
  input  logic        halt_req,
  input  logic        run_req,
  input  logic        step_req,
  output logic        pipe_en,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idexe_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, STEP = 2'd2} st_e;
  st_e         state_q, state_d;
  logic [15:0] stall_q, stall_d, flush_q, flush_d;
  logic        load_use, do_flush, do_stall;
  always_comb begin
    state_d = (state_q == RUN)  ? (halt_req ? HALT : RUN) :
              (state_q == HALT) ? (run_req ? RUN : (step_req ? STEP : HALT)) :
              (state_q == STEP) ? HALT : RUN;
    pipe_en     = (state_q == RUN) || (state_q == STEP);
    load_use    = exe_m2reg & exe_wreg & (exe_d != 5'd0) &
                  ((id_use_rs & (id_rs == exe_d)) | (id_use_rt & (id_rt == exe_d)));
    // branch redirect wins over a load-use stall in the same cycle
    do_flush    = pipe_en & btaken;
    do_stall    = pipe_en & ~btaken & load_use;
    pc_en       = pipe_en & ~do_stall;
    ifid_en     = pipe_en & ~do_stall;
    ifid_flush  = do_flush;
    idexe_flush = do_flush | do_stall;
    stall_d     = stall_q + {15'd0, do_stall & (stall_q != 16'hFFFF)};
    flush_d     = flush_q + {15'd0, do_flush & (flush_q != 16'hFFFF)};
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign state     = state_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic        Clock = 1'b0, Reset = 1'b1;
  logic [4:0]  id_rs, id_rt, exe_d;
  logic        id_use_rs, id_use_rt, exe_wreg, exe_m2reg, btaken;
  logic        halt_req, run_req, step_req;
  logic        pipe_en, pc_en, ifid_en, ifid_flush, idexe_flush;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;
  int          checks = 0, errors = 0, pe_cycles;
  pipe_hazard_ctrl dut (
    .Clock(Clock), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .exe_d(exe_d),
    .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .btaken(btaken),
    .halt_req(halt_req), .run_req(run_req), .step_req(step_req),
    .pipe_en(pipe_en), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idexe_flush(idexe_flush), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 Clock = ~Clock;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask
  task automatic idle();
    {id_rs, id_rt, exe_d} = '0;
    {id_use_rs, id_use_rt, exe_wreg, exe_m2reg, btaken} = '0;
    {halt_req, run_req, step_req} = '0;
  endtask
  task automatic ctl(input string tag, input logic [4:0] exp);
    #1;
    check(tag, {27'd0, pipe_en, pc_en, ifid_en, ifid_flush, idexe_flush}, {27'd0, exp});
  endtask
  task automatic set_lu(input logic [4:0] d);
    exe_m2reg = 1'b1; exe_wreg = 1'b1; exe_d = d; id_rs = d; id_use_rs = 1'b1;
  endtask
  task automatic do_reset();
    idle();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask
  initial begin
    do_reset();
    check("rst_state", state, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_flush", flush_cnt, 0);
    ctl("idle_ctl", 5'b11100);
    set_lu(5'd5);
    ctl("lu_rs_ctl", 5'b10001);
    tick();
    idle();
    check("lu_rs_cnt", stall_cnt, 1);
    ctl("lu_release", 5'b11100);
    exe_m2reg = 1; exe_wreg = 1; exe_d = 7; id_rt = 7; id_use_rt = 1;
    ctl("lu_rt_ctl", 5'b10001);
    id_use_rt = 0;
    ctl("rt_unused", 5'b11100);
    id_use_rt = 1; exe_wreg = 0;
    ctl("no_wreg", 5'b11100);
    exe_wreg = 1; exe_m2reg = 0;
    ctl("no_load", 5'b11100);
    idle();
    set_lu(5'd0);
    ctl("r0_ctl", 5'b11100);
    tick();
    check("r0_cnt", stall_cnt, 1);
    do_reset();
    set_lu(5'd9);
    btaken = 1;
    ctl("br_lu_ctl", 5'b11111);
    tick();
    idle();
    check("br_flush_cnt", flush_cnt, 1);
    check("br_stall_cnt", stall_cnt, 0);
    halt_req = 1;
    tick();
    halt_req = 0;
    check("halt_state", state, 1);
    pe_cycles = 0;
    set_lu(5'd3);
    btaken = 1;
    ctl("halt_ctl", 5'b00000);
    tick();
    check("halt_hold_cnt", {stall_cnt, flush_cnt}, {16'd0, 16'd1});
    idle();
    halt_req = 1;
    tick();
    check("halt_in_halt", state, 1);
    halt_req = 0; run_req = 1; step_req = 1;
    tick();
    check("run_prio", state, 0);
    idle();
    halt_req = 1;
    tick();
    halt_req = 0;
    step_req = 1;
    tick();
    step_req = 0;
    check("step_state", state, 2);
    set_lu(5'd4);
    ctl("step_lu_ctl", 5'b10001);
    pe_cycles += pipe_en;
    tick();
    idle();
    check("step_back", state, 1);
    check("step_stall", stall_cnt, 1);
    pe_cycles += pipe_en;
    tick();
    check("step_idle", state, 1);
    pe_cycles += pipe_en;
    check("step_pe_cycles", pe_cycles, 1);
    step_req = 1;
    tick();
    step_req = 0;
    check("step2_state", state, 2);
    Reset = 1;
    tick();
    Reset = 0;
    check("rst_step_state", state, 0);
    check("rst_step_cnts", {stall_cnt, flush_cnt}, 0);
    check("rst_step_pe", pipe_en, 1);
    set_lu(5'd6);
    for (int i = 0; i < 65534; i++) tick();
    check("sat_pre", stall_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) tick();
    check("sat_hold", stall_cnt, 16'hFFFF);
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports: Clock  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port: Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have ports: id_use_rs, id_use_rt  in  1 each  high when the ID instruction actually reads rs / rt.
REQ-005 SHALL have ports: exe_d  in  5  destination register in EXE; exe_wreg, exe_m2reg  in  1 each  EXE writes a register / EXE is a load.
REQ-006 SHALL have port: btaken  in  1  conditional branch resolved taken in EXE.
REQ-007 SHALL have ports: halt_req, run_req, step_req  in  1 each  debug halt, resume and single-step pulses.
REQ-008 SHALL have ports: pipe_en  out  1  global enable for all pipeline registers and the register file write.
REQ-009 SHALL have ports: pc_en, ifid_en  out  1 each  PC / IF-ID register load enables.
REQ-010 SHALL have ports: ifid_flush, idexe_flush  out  1 each  insert a bubble (NOP, all write enables 0) into IF-ID / ID-EXE.
REQ-011 SHALL have ports: state  out  2  FSM state; stall_cnt, flush_cnt  out  16 each  event counters.

Function
REQ-012 SHALL implement FSM states RUN=2'd0, HALT=2'd1, STEP=2'd2; 2'd3 is illegal and SHALL go to RUN on the next edge.
REQ-013 SHALL transition RUN->HALT on halt_req; HALT->STEP on step_req; HALT->RUN on run_req; STEP->HALT unconditionally after one cycle.
REQ-014 SHALL give run_req priority over step_req in HALT, and halt_req no effect outside RUN.
REQ-015 SHALL drive pipe_en=1 in RUN and STEP and 0 in HALT, combinationally from state.
REQ-016 SHALL define load_use = exe_m2reg & exe_wreg & (exe_d!=0) & ((id_use_rs & id_rs==exe_d) | (id_use_rt & id_rt==exe_d)), combinational.
REQ-017 SHALL, when pipe_en=1 and btaken=1, drive pc_en=1, ifid_en=1, ifid_flush=1, idexe_flush=1 in the same cycle; the flush takes effect at the next edge.
REQ-018 SHALL, when pipe_en=1, btaken=0 and load_use=1, drive pc_en=0, ifid_en=0, ifid_flush=0, idexe_flush=1, giving exactly one bubble cycle.
REQ-019 SHALL, when pipe_en=1 and neither condition holds, drive pc_en=1, ifid_en=1, both flushes 0.
REQ-020 SHALL give btaken priority over load_use in the same cycle.
REQ-021 SHALL, when pipe_en=0, drive pc_en=0, ifid_en=0, both flushes 0, ignoring btaken and load_use.
REQ-022 SHALL increment stall_cnt at each edge where REQ-018 applies and flush_cnt at each edge where REQ-017 applies; both saturate at 16'hFFFF.
REQ-023 SHALL evaluate hazards in STEP exactly as in RUN, so a step cycle can stall or flush.
REQ-024 SHALL have zero-cycle latency from hazard inputs to control outputs; only state and counters are registered.

Reset
REQ-025 SHALL on Reset=1 at an edge set state=RUN and stall_cnt=flush_cnt=0, overriding all other inputs.
REQ-026 SHALL keep outputs purely combinational during reset, so pipe_en=1 after the first reset edge.
REQ-027 SHALL abort a pending step when reset is asserted mid-STEP, returning to RUN.

Verification
REQ-028 SHALL cover this load-use case: exe_m2reg=1, exe_wreg=1, exe_d=5, id_rs=5, id_use_rs=1 -> pc_en=0, ifid_en=0, idexe_flush=1 for one cycle, then stall_cnt=1.
REQ-029 SHALL cover exe_d=0 with a matching id_rs=0 -> no stall and stall_cnt unchanged.
REQ-030 SHALL cover btaken=1 together with load_use=1 -> ifid_flush=1, idexe_flush=1, pc_en=1, then flush_cnt=1 and stall_cnt=0.
REQ-031 SHALL cover this sequence: halt_req, then step_req, then two idle cycles -> state 0->1->2->1, with pipe_en high for exactly one cycle.
REQ-032 SHALL cover stall_cnt preloaded to 16'hFFFE followed by 3 load-use cycles -> stall_cnt holds 16'hFFFF.
REQ-033 SHALL cover Reset asserted in STEP with counters nonzero -> state=0 and counters 0 at the next edge.
